clk_rst_mgr: RTL and testbench
==============================

Name: clk_rst_mgr

Overview:
- Sequencer that sits directly downstream of the 40 MHz→100 MHz MMCM clock generator. It consumes the MMCM's LOCKED output and drives back that MMCM's RST input.
- Runs on the free-running 40 MHz board clock, so it keeps operating while the MMCM is unlocked.
- Holds system reset until lock has been stable, re-initialises the MMCM on lock timeout or lock loss, and counts lock-loss events for status readout.

Parameters:
- RST_CYCLES, 16, width of each mmcm_rst_o pulse in clk40m_i cycles (≥1)
- LOCK_TIMEOUT, 4000, cycles allowed in WAIT_LOCK before retry (100 µs)
- STABLE_CYCLES, 256, consecutive synchronised-locked cycles required before releasing sys_rst_o
- MAX_RETRIES, 4, consecutive timeouts before FAIL (used only with the optional feature)
- CNT_W, 8, width of lock_lost_cnt_o

Ports:
- clk40m_i  input  1  free-running 40 MHz clock
- reset  input  1  asynchronous, active-high reset
- locked_i  input  1  MMCM LOCKED, asynchronous to clk40m_i
- soft_rst_i  input  1  synchronous re-initialisation request, level, active-high
- mmcm_rst_o  output  1  drives MMCM RST
- sys_rst_o  output  1  active-high system reset; downstream 100 MHz logic re-synchronises it
- ready_o  output  1  high in RUN
- fail_o  output  1  high in FAIL
- retry_cnt_o  output  3  consecutive lock timeouts, saturating at 7
- lock_lost_cnt_o  output  CNT_W  lock losses seen in RUN, saturating
- state_o  output  3  encoded state: RST_MMCM=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4

Behaviour:
- All outputs are registered.
- Reset values:
  - state RST_MMCM, mmcm_rst_o=1, sys_rst_o=1
  - ready_o=0, fail_o=0
  - retry_cnt_o=0, lock_lost_cnt_o=0
  - internal counter=0
- locked_i passes through a 2-FF synchroniser to give locked_s (latency 2 cycles). The synchroniser flops reset to 0.
- A single shared counter `cnt` is zeroed on every state entry.
- RST_MMCM:
  - mmcm_rst_o=1, sys_rst_o=1.
  - Exit to WAIT_LOCK when cnt==RST_CYCLES-1, so mmcm_rst_o is high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - mmcm_rst_o=0, sys_rst_o=1.
  - locked_s=1 → STABLE.
  - Otherwise, at cnt==LOCK_TIMEOUT-1 → RST_MMCM and retry_cnt increments (saturating).
- STABLE:
  - locked_s=0 → WAIT_LOCK, cnt restarts; retry_cnt is unchanged.
  - cnt==STABLE_CYCLES-1 with locked_s=1 → RUN, and retry_cnt is cleared.
- RUN:
  - sys_rst_o=0, ready_o=1.
  - locked_s=0 → RST_MMCM and lock_lost_cnt increments, saturating at all-ones.
  - sys_rst_o rises and ready_o falls in the same cycle mmcm_rst_o rises.
- Timing: sys_rst_o falls exactly STABLE_CYCLES cycles after the first cycle locked_s is seen high in WAIT_LOCK.
- soft_rst_i has highest priority in every state:
  - Next state RST_MMCM, cnt cleared, retry_cnt cleared, fail_o cleared.
  - lock_lost_cnt is not incremented by soft_rst_i.
  - If held high, the block stays in RST_MMCM with mmcm_rst_o=1; the RST_CYCLES count starts after release.
- Simultaneous locked_s fall and soft_rst_i in RUN: the soft reset wins and lock_lost_cnt is not incremented.
- lock_lost_cnt_o is cleared only by reset.
- The async reset mid-operation returns all state to the reset values immediately.

Optional Feature:
- Macro CLK_RST_MGR_RETRY_LIMIT_EN.
- Defined:
  - A WAIT_LOCK timeout that makes retry_cnt reach MAX_RETRIES goes to FAIL instead of RST_MMCM.
  - FAIL holds mmcm_rst_o=1, sys_rst_o=1, ready_o=0, fail_o=1.
  - FAIL is left only via soft_rst_i or reset.
- Not defined:
  - Retries are unlimited and the FAIL state does not exist.
  - fail_o is tied to 0.
  - retry_cnt_o still counts and saturates.

Test Plan:
- Power-up with locked_i rising 500 cycles after mmcm_rst_o falls → mmcm_rst_o high for 16 cycles, then sys_rst_o falls 256 cycles after locked_s rises, and ready_o=1, state_o=3.
- locked_i held 0 → mmcm_rst_o re-pulses every 4016 cycles and retry_cnt_o counts 1,2,3…. With the macro defined, after the 4th timeout state_o=4, fail_o=1, mmcm_rst_o stays 1.
- locked_i glitches low for 3 cycles at STABLE cnt=100 → return to WAIT_LOCK, then RUN entered 256 cycles after relock, with sys_rst_o high throughout.
- In RUN, drop locked_i 3 times → lock_lost_cnt_o=3, each drop gives a 16-cycle mmcm_rst_o pulse and sys_rst_o reasserted. With CNT_W=2 and 5 drops, lock_lost_cnt_o saturates at 3.
- soft_rst_i pulsed 1 cycle in RUN, and in FAIL → RST_MMCM next cycle, retry_cnt_o=0, fail_o=0, lock_lost_cnt_o unchanged.
- Assert reset during WAIT_LOCK cnt=2000 → all outputs return to reset values asynchronously, and the sequence restarts cleanly on release.

Source files
------------

// File: rtl/clk_rst_mgr.sv
// Reset sequencer for the 40->100 MHz MMCM: pulses MMCM RST, waits for a stable lock, then releases sys_rst_o.
// Optional macro CLK_RST_MGR_RETRY_LIMIT_EN adds a FAIL state after MAX_RETRIES consecutive lock timeouts.
module clk_rst_mgr #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4000,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk40m_i,
    input  logic             reset,
    input  logic             locked_i,
    input  logic             soft_rst_i,
    output logic             mmcm_rst_o,
    output logic             sys_rst_o,
    output logic             ready_o,
    output logic             fail_o,
    output logic [2:0]       retry_cnt_o,
    output logic [CNT_W-1:0] lock_lost_cnt_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_RST_MMCM  = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

`ifdef CLK_RST_MGR_RETRY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    // One counter serves all timed states, so it must hold the largest terminal count.
    localparam int MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int MAX_C = (MAX_A > RST_CYCLES) ? MAX_A : RST_CYCLES;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    retry_nxt;
    logic [2:0]    retry_inc;
    logic          retry_hit;
    logic          lost_inc;
    logic [1:0]    sync_q;
    logic          locked_s;

    // LOCKED comes from the MMCM's own domain; two flops before any decision uses it.
    always_ff @(posedge clk40m_i or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], locked_i};
        end
    end

    assign locked_s  = sync_q[1];
    assign retry_inc = (retry_cnt_o == 3'd7) ? 3'd7 : retry_cnt_o + 3'd1;
    assign retry_hit = (int'(retry_cnt_o) + 1) >= MAX_RETRIES;
    assign state_o   = state;

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt_o;
        lost_inc  = 1'b0;
        if (soft_rst_i) begin
            state_nxt = S_RST_MMCM;
            retry_nxt = 3'd0;
        end else begin
            case (state)
                S_RST_MMCM: begin
                    if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = S_STABLE;
                    end else if (cnt == TO_LAST) begin
                        retry_nxt = retry_inc;
                        state_nxt = (LIMIT_EN && retry_hit) ? S_FAIL : S_RST_MMCM;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_nxt = S_WAIT_LOCK;
                    end else if (cnt == ST_LAST) begin
                        state_nxt = S_RUN;
                        retry_nxt = 3'd0;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_nxt = S_RST_MMCM;
                        lost_inc  = 1'b1;
                    end
                end
                S_FAIL: begin
                    state_nxt = S_FAIL;
                end
                default: begin
                    state_nxt = S_RST_MMCM;
                end
            endcase
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (soft_rst_i || (state_nxt != state)) begin
            cnt_nxt = '0;
        end else if (state == S_RST_MMCM || state == S_WAIT_LOCK || state == S_STABLE) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state_o.
    always_ff @(posedge clk40m_i or posedge reset) begin
        if (reset) begin
            state           <= S_RST_MMCM;
            cnt             <= '0;
            retry_cnt_o     <= 3'd0;
            lock_lost_cnt_o <= '0;
            mmcm_rst_o      <= 1'b1;
            sys_rst_o       <= 1'b1;
            ready_o         <= 1'b0;
`ifdef CLK_RST_MGR_RETRY_LIMIT_EN
            fail_o          <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_cnt_o <= retry_nxt;
            if (lost_inc && (lock_lost_cnt_o != {CNT_W{1'b1}})) begin
                lock_lost_cnt_o <= lock_lost_cnt_o + 1'b1;
            end
            mmcm_rst_o <= (state_nxt == S_RST_MMCM) || (state_nxt == S_FAIL);
            sys_rst_o  <= (state_nxt != S_RUN);
            ready_o    <= (state_nxt == S_RUN);
`ifdef CLK_RST_MGR_RETRY_LIMIT_EN
            fail_o     <= (state_nxt == S_FAIL);
`endif
        end
    end

`ifndef CLK_RST_MGR_RETRY_LIMIT_EN
    assign fail_o = 1'b0;
`endif

endmodule

// File: tb/tb_clk_rst_mgr.sv
// Directed bench for clk_rst_mgr: power-up, lock loss, glitch, soft reset, lock timeouts and async reset.
`timescale 1ns/1ps
module tb_clk_rst_mgr;

    logic       clk = 1'b0;
    logic       reset;
    logic       locked_i;
    logic       soft_rst_i;
    logic       mmcm_rst_o, sys_rst_o, ready_o, fail_o;
    logic [2:0] retry_cnt_o, state_o;
    logic [7:0] lost_o;
    logic       mmcm2, sys2, ready2, fail2;
    logic [2:0] retry2, state2;
    logic [1:0] lost2;

    logic [2:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         exp_lost = 0;

    clk_rst_mgr dut (
        .clk40m_i(clk), .reset(reset), .locked_i(locked_i), .soft_rst_i(soft_rst_i),
        .mmcm_rst_o(mmcm_rst_o), .sys_rst_o(sys_rst_o), .ready_o(ready_o), .fail_o(fail_o),
        .retry_cnt_o(retry_cnt_o), .lock_lost_cnt_o(lost_o), .state_o(state_o)
    );

    clk_rst_mgr #(.CNT_W(2)) dut2 (
        .clk40m_i(clk), .reset(reset), .locked_i(locked_i), .soft_rst_i(soft_rst_i),
        .mmcm_rst_o(mmcm2), .sys_rst_o(sys2), .ready_o(ready2), .fail_o(fail2),
        .retry_cnt_o(retry2), .lock_lost_cnt_o(lost2), .state_o(state2)
    );

    // clock / reset
    always #12 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // driver / measurement tasks
    task automatic count_mmcm(input logic lvl, input int budget, output int n);
        n = 0;
        while (mmcm_rst_o === lvl && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic dwell(input logic [2:0] st, input int budget, output int n, output int sys_low);
        n = 0;
        sys_low = 0;
        while (state_o === st && n < budget) begin
            if (sys_rst_o !== 1'b1) sys_low++;
            tick();
            n++;
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n;
        n = 0;
        while (state_o !== st && n < budget) begin
            tick();
            n++;
        end
        check(tag, state_o, st);
    endtask

    task automatic soft_pulse();
        soft_rst_i = 1'b1;
        tick();
        soft_rst_i = 1'b0;
    endtask

    initial begin
        int n, low, n_to;
        reset = 1'b1; locked_i = 1'b0; soft_rst_i = 1'b0;
        tick(3);
        check("rst_state", state_o, 0);
        check("rst_mmcm", mmcm_rst_o, 1);
        check("rst_sys", sys_rst_o, 1);
        check("rst_ready", ready_o, 0);
        check("rst_fail", fail_o, 0);
        check("rst_retry", retry_cnt_o, 0);
        check("rst_lost", lost_o, 0);

        // power-up: 16-cycle MMCM pulse, lock 500 cycles later, 256 cycles of STABLE
        reset = 1'b0;
        count_mmcm(1'b1, 100, n);
        check("pwr_pulse_width", n, 16);
        check("pwr_wait_state", state_o, 1);
        tick(500);
        locked_i = 1'b1;
        dwell(3'd1, 100, n, low);
        check("pwr_sync_latency", n, 3);
        dwell(3'd2, 400, n, low);
        check("pwr_stable_len", n, 256);
        check("pwr_stable_sys_hi", low, 0);
        check("pwr_run_state", state_o, 3);
        check("pwr_run_sys", sys_rst_o, 0);
        check("pwr_run_ready", ready_o, 1);
        check("pwr_run_mmcm", mmcm_rst_o, 0);

        // five lock losses in RUN; the 2-bit counter instance saturates at 3
        for (int i = 1; i <= 5; i++) begin
            locked_i = 1'b0;
            count_mmcm(1'b0, 20, n);
            check("drop_latency", n, 3);
            check("drop_sys_rise", sys_rst_o, 1);
            check("drop_ready_fall", ready_o, 0);
            exp_lost++;
            check("drop_lost", lost_o, exp_lost);
            check("drop_lost_sat", lost2, (i > 3) ? 3 : i);
            locked_i = 1'b1;
            count_mmcm(1'b1, 100, n);
            check("drop_pulse_width", n, 16);
            wait_state(3'd3, 400, "drop_relock_run");
        end

        // 3-cycle glitch at STABLE cnt=100
        locked_i = 1'b0;
        count_mmcm(1'b0, 20, n);
        exp_lost++;
        locked_i = 1'b1;
        wait_state(3'd2, 100, "glitch_enter_stable");
        tick(100);
        locked_i = 1'b0;
        tick(3);
        locked_i = 1'b1;
        check("glitch_back_wait", state_o, 1);
        check("glitch_retry", retry_cnt_o, 0);
        dwell(3'd1, 20, n, low);
        check("glitch_wait_sys_hi", low, 0);
        dwell(3'd2, 400, n, low);
        check("glitch_stable_len", n, 256);
        check("glitch_stable_sys_hi", low, 0);
        check("glitch_run", state_o, 3);

        // one-cycle soft reset in RUN
        soft_pulse();
        check("soft_state", state_o, 0);
        check("soft_mmcm", mmcm_rst_o, 1);
        check("soft_sys", sys_rst_o, 1);
        check("soft_ready", ready_o, 0);
        check("soft_lost_kept", lost_o, exp_lost);
        count_mmcm(1'b1, 100, n);
        check("soft_pulse_width", n, 16);
        wait_state(3'd3, 400, "soft_relock_run");

        // held soft reset: pulse length counted from release
        soft_rst_i = 1'b1;
        tick(40);
        check("soft_hold_state", state_o, 0);
        check("soft_hold_mmcm", mmcm_rst_o, 1);
        soft_rst_i = 1'b0;
        count_mmcm(1'b1, 100, n);
        check("soft_hold_width", n, 16);
        wait_state(3'd3, 400, "soft_hold_run");

        // lock loss and soft reset reach the FSM on the same edge
        locked_i = 1'b0;
        tick(2);
        soft_rst_i = 1'b1;
        tick();
        soft_rst_i = 1'b0;
        check("simul_state", state_o, 0);
        check("simul_lost_kept", lost_o, exp_lost);
        locked_i = 1'b1;
        wait_state(3'd3, 400, "simul_run");

        // lock timeouts with locked_i held low
        locked_i = 1'b0;
        soft_pulse();
        count_mmcm(1'b1, 100, n);
        check("to_first_pulse", n, 16);
`ifdef CLK_RST_MGR_RETRY_LIMIT_EN
        n_to = 4;
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd4};
`else
        n_to = 8;
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
`endif
        for (int k = 1; k <= n_to; k++) begin
            count_mmcm(1'b0, 5000, n);
            check("to_wait_len", n, 4000);
            check("to_retry", retry_cnt_o, exp_q.pop_front());
`ifdef CLK_RST_MGR_RETRY_LIMIT_EN
            if (k == n_to) break;
`endif
            count_mmcm(1'b1, 100, n);
            check("to_pulse_width", n, 16);
        end
`ifdef CLK_RST_MGR_RETRY_LIMIT_EN
        check("fail_state", state_o, 4);
        check("fail_flag", fail_o, 1);
        check("fail_sys", sys_rst_o, 1);
        tick(50);
        check("fail_hold_state", state_o, 4);
        check("fail_hold_mmcm", mmcm_rst_o, 1);
        soft_pulse();
        check("fail_soft_state", state_o, 0);
        check("fail_soft_flag", fail_o, 0);
        check("fail_soft_retry", retry_cnt_o, 0);
        check("fail_soft_lost", lost_o, exp_lost);
        count_mmcm(1'b1, 100, n);
        check("fail_soft_width", n, 16);
        locked_i = 1'b1;
`else
        check("to_no_fail", fail_o, 0);
        locked_i = 1'b1;
        wait_state(3'd2, 100, "to_lock_stable");
        check("to_stable_retry", retry_cnt_o, 7);
`endif
        wait_state(3'd3, 400, "to_lock_run");
        check("to_run_retry_clr", retry_cnt_o, 0);

        // async reset in WAIT_LOCK at cnt=2000
        locked_i = 1'b0;
        count_mmcm(1'b0, 20, n);
        exp_lost++;
        wait_state(3'd1, 100, "ar_enter_wait");
        tick(2000);
        check("ar_lost_before", lost_o, exp_lost);
        #2 reset = 1'b1;
        #2;
        check("ar_state", state_o, 0);
        check("ar_mmcm", mmcm_rst_o, 1);
        check("ar_sys", sys_rst_o, 1);
        check("ar_ready", ready_o, 0);
        check("ar_retry", retry_cnt_o, 0);
        check("ar_lost", lost_o, 0);
        tick(2);
        locked_i = 1'b1;
        reset = 1'b0;
        count_mmcm(1'b1, 100, n);
        check("ar_restart_width", n, 16);
        wait_state(3'd3, 400, "ar_restart_run");
        check("ar_restart_sys", sys_rst_o, 0);
        check("ar_restart_lost", lost_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
